// File: rtl/mips_regfile_2w.sv
// -----------------------------------------------------------------------------
// mips_regfile_2w
// Dual-write MIPS register file for the dual-issue datapath.
//
// Two combinational read ports, two synchronous write ports (A and B), and a
// per-register busy scoreboard used by issue logic to spot pending producers.
//
// Parameters
//   DATA_W   : register / data width
//   ADDR_W   : address width, depth = 2**ADDR_W
//   ZERO_REG : 1 = register 0 reads 0, ignores writes, is never busy
//   BYPASS   : 1 = read of a register written this cycle returns new data and
//              reports not busy
//
// Ports
//   clk, rst                         : rising-edge clock, sync active-high reset
//   read_reg_1/2 -> read_data_1/2    : combinational read ports
//   write_reg_a/write_data_a/signal_reg_write_a : write port A
//   write_reg_b/write_data_b/signal_reg_write_b : write port B (wins collisions)
//   busy_set_reg/signal_busy_set     : mark a register busy (producer issued)
//   busy_1/2                         : busy bit of read_reg_1/2
//   busy_any                         : OR of the registered busy vector
// -----------------------------------------------------------------------------
module mips_regfile_2w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic [ADDR_W-1:0] write_reg_a,
  input  logic [DATA_W-1:0] write_data_a,
  input  logic              signal_reg_write_a,
  input  logic [ADDR_W-1:0] write_reg_b,
  input  logic [DATA_W-1:0] write_data_b,
  input  logic              signal_reg_write_b,
  input  logic [ADDR_W-1:0] busy_set_reg,
  input  logic              signal_busy_set,
  output logic              busy_1,
  output logic              busy_2,
  output logic              busy_any
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam bit ZR_EN  = (ZERO_REG != 0);
  localparam bit BYP_EN = (BYPASS != 0);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic              w_we_a;
  logic              w_we_b;
  logic              w_bset;
  logic [DEPTH-1:0]  w_busy_next;

  logic              w_byp1_a, w_byp1_b, w_byp2_a, w_byp2_b;
  logic              w_zero1, w_zero2;

  // Effective enables: writes / busy-sets aimed at a hardwired zero register
  // are dropped here so storage, scoreboard and bypass all see the same thing.
  assign w_we_a = signal_reg_write_a && !(ZR_EN && (write_reg_a == '0));
  assign w_we_b = signal_reg_write_b && !(ZR_EN && (write_reg_b == '0));
  assign w_bset = signal_busy_set    && !(ZR_EN && (busy_set_reg == '0));

  // Bypass is suppressed while rst is high: the edge will clear the array, so
  // forwarding write data through it would show a value that never lands.
  assign w_byp1_a = BYP_EN && !rst && w_we_a && (read_reg_1 == write_reg_a);
  assign w_byp1_b = BYP_EN && !rst && w_we_b && (read_reg_1 == write_reg_b);
  assign w_byp2_a = BYP_EN && !rst && w_we_a && (read_reg_2 == write_reg_a);
  assign w_byp2_b = BYP_EN && !rst && w_we_b && (read_reg_2 == write_reg_b);

  assign w_zero1 = ZR_EN && (read_reg_1 == '0);
  assign w_zero2 = ZR_EN && (read_reg_2 == '0);

  // Scoreboard update: writes retire producers, then a busy-set is applied
  // last so a freshly issued producer on the same register wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_we_a) w_busy_next[write_reg_a] = 1'b0;
    if (w_we_b) w_busy_next[write_reg_b] = 1'b0;
    if (w_bset) w_busy_next[busy_set_reg] = 1'b1;
  end

  // Storage. Port B is assigned after port A, so on an address collision the
  // younger instruction's data is the one kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_we_a) r_mem[write_reg_a] <= write_data_a;
      if (w_we_b) r_mem[write_reg_b] <= write_data_b;
      r_busy <= w_busy_next;
    end
  end

  // Read port 1: array, then A bypass, then B bypass (B beats A), then zero.
  always_comb begin
    read_data_1 = r_mem[read_reg_1];
    busy_1      = r_busy[read_reg_1];
    if (w_byp1_a) begin
      read_data_1 = write_data_a;
      busy_1      = 1'b0;
    end
    if (w_byp1_b) begin
      read_data_1 = write_data_b;
      busy_1      = 1'b0;
    end
    if (w_zero1) begin
      read_data_1 = '0;
      busy_1      = 1'b0;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    read_data_2 = r_mem[read_reg_2];
    busy_2      = r_busy[read_reg_2];
    if (w_byp2_a) begin
      read_data_2 = write_data_a;
      busy_2      = 1'b0;
    end
    if (w_byp2_b) begin
      read_data_2 = write_data_b;
      busy_2      = 1'b0;
    end
    if (w_zero2) begin
      read_data_2 = '0;
      busy_2      = 1'b0;
    end
  end

  assign busy_any = |r_busy;

endmodule

// File: tb/tb_mips_regfile_2w.sv
module tb_mips_regfile_2w;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default instance: DATA_W=32, ADDR_W=5, ZERO_REG=1, BYPASS=1
  logic        rst;
  logic [4:0]  read_reg_1, read_reg_2;
  logic [31:0] read_data_1, read_data_2;
  logic [4:0]  write_reg_a, write_reg_b, busy_set_reg;
  logic [31:0] write_data_a, write_data_b;
  logic        signal_reg_write_a, signal_reg_write_b, signal_busy_set;
  logic        busy_1, busy_2, busy_any;

  mips_regfile_2w dut (
    .clk(clk), .rst(rst),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .write_reg_a(write_reg_a), .write_data_a(write_data_a),
    .signal_reg_write_a(signal_reg_write_a),
    .write_reg_b(write_reg_b), .write_data_b(write_data_b),
    .signal_reg_write_b(signal_reg_write_b),
    .busy_set_reg(busy_set_reg), .signal_busy_set(signal_busy_set),
    .busy_1(busy_1), .busy_2(busy_2), .busy_any(busy_any)
  );

  // Sweep instance: DATA_W=16, ADDR_W=3, BYPASS=0, ZERO_REG=0
  logic        p_rst;
  logic [2:0]  p_read_reg_1, p_read_reg_2;
  logic [15:0] p_read_data_1, p_read_data_2;
  logic [2:0]  p_write_reg_a, p_write_reg_b, p_busy_set_reg;
  logic [15:0] p_write_data_a, p_write_data_b;
  logic        p_we_a, p_we_b, p_bset;
  logic        p_busy_1, p_busy_2, p_busy_any;

  mips_regfile_2w #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_p (
    .clk(clk), .rst(p_rst),
    .read_reg_1(p_read_reg_1), .read_reg_2(p_read_reg_2),
    .read_data_1(p_read_data_1), .read_data_2(p_read_data_2),
    .write_reg_a(p_write_reg_a), .write_data_a(p_write_data_a),
    .signal_reg_write_a(p_we_a),
    .write_reg_b(p_write_reg_b), .write_data_b(p_write_data_b),
    .signal_reg_write_b(p_we_b),
    .busy_set_reg(p_busy_set_reg), .signal_busy_set(p_bset),
    .busy_1(p_busy_1), .busy_2(p_busy_2), .busy_any(p_busy_any)
  );

  // ---------------- driver tasks ----------------
  // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    signal_reg_write_a = 1'b0; signal_reg_write_b = 1'b0; signal_busy_set = 1'b0;
    write_reg_a = '0; write_reg_b = '0; busy_set_reg = '0;
    write_data_a = '0; write_data_b = '0;
    p_we_a = 1'b0; p_we_b = 1'b0; p_bset = 1'b0;
    p_write_reg_a = '0; p_write_reg_b = '0; p_busy_set_reg = '0;
    p_write_data_a = '0; p_write_data_b = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; p_rst = 1'b1;
    read_reg_1 = 5'd5; read_reg_2 = 5'd31;
    p_read_reg_1 = 3'd0; p_read_reg_2 = 3'd7;
    tick();
    rst = 1'b0; p_rst = 1'b0;
    settle();
    total++; if (read_data_1 !== 32'h0) begin bad++; $display("FAIL reset_rd1: got %h want %h", read_data_1, 32'h0); end
    total++; if (read_data_2 !== 32'h0) begin bad++; $display("FAIL reset_rd2: got %h want %h", read_data_2, 32'h0); end
    total++; if ({busy_1, busy_2, busy_any} !== 3'b000) begin bad++; $display("FAIL reset_busy: got %b want 000", {busy_1, busy_2, busy_any}); end
    total++; if (p_read_data_2 !== 16'h0) begin bad++; $display("FAIL reset_p_rd2: got %h want %h", p_read_data_2, 16'h0); end
  endtask

  task automatic test_single_write();
    read_reg_1 = 5'd5; read_reg_2 = 5'd6;
    write_reg_a = 5'd5; write_data_a = 32'hDEADBEEF; signal_reg_write_a = 1'b1;
    settle();
    // Bypass makes the new value visible in the write cycle itself.
    total++; if (read_data_1 !== 32'hDEADBEEF) begin bad++; $display("FAIL single_bypass: got %h want %h", read_data_1, 32'hDEADBEEF); end
    total++; if (read_data_2 !== 32'h0) begin bad++; $display("FAIL single_other: got %h want %h", read_data_2, 32'h0); end
    tick();
    idle_inputs();
    settle();
    total++; if (read_data_1 !== 32'hDEADBEEF) begin bad++; $display("FAIL single_commit: got %h want %h", read_data_1, 32'hDEADBEEF); end
  endtask

  task automatic test_collision();
    write_reg_a = 5'd7; write_data_a = 32'h11; signal_reg_write_a = 1'b1;
    write_reg_b = 5'd7; write_data_b = 32'h22; signal_reg_write_b = 1'b1;
    read_reg_1 = 5'd7;
    settle();
    total++; if (read_data_1 !== 32'h22) begin bad++; $display("FAIL coll_bypass_b_wins: got %h want %h", read_data_1, 32'h22); end
    tick();
    write_reg_a = 5'd3; write_data_a = 32'h33;
    write_reg_b = 5'd4; write_data_b = 32'h44;
    read_reg_1 = 5'd3; read_reg_2 = 5'd4;
    settle();
    total++; if (read_data_1 !== 32'h33) begin bad++; $display("FAIL coll_bypass_a: got %h want %h", read_data_1, 32'h33); end
    total++; if (read_data_2 !== 32'h44) begin bad++; $display("FAIL coll_bypass_b: got %h want %h", read_data_2, 32'h44); end
    tick();
    idle_inputs();
    read_reg_1 = 5'd7; read_reg_2 = 5'd3;
    settle();
    total++; if (read_data_1 !== 32'h22) begin bad++; $display("FAIL coll_reg7: got %h want %h", read_data_1, 32'h22); end
    total++; if (read_data_2 !== 32'h33) begin bad++; $display("FAIL coll_reg3: got %h want %h", read_data_2, 32'h33); end
    read_reg_1 = 5'd4;
    settle();
    total++; if (read_data_1 !== 32'h44) begin bad++; $display("FAIL coll_reg4: got %h want %h", read_data_1, 32'h44); end
  endtask

  task automatic test_zero_reg();
    write_reg_a = 5'd0; write_data_a = 32'hFFFFFFFF; signal_reg_write_a = 1'b1;
    write_reg_b = 5'd0; write_data_b = 32'hFFFFFFFF; signal_reg_write_b = 1'b1;
    busy_set_reg = 5'd0; signal_busy_set = 1'b1;
    read_reg_1 = 5'd0; read_reg_2 = 5'd0;
    settle();
    total++; if (read_data_1 !== 32'h0) begin bad++; $display("FAIL zero_no_bypass: got %h want %h", read_data_1, 32'h0); end
    tick();
    idle_inputs();
    settle();
    total++; if (read_data_2 !== 32'h0) begin bad++; $display("FAIL zero_stays0: got %h want %h", read_data_2, 32'h0); end
    total++; if ({busy_1, busy_any} !== 2'b00) begin bad++; $display("FAIL zero_busy: got %b want 00", {busy_1, busy_any}); end
  endtask

  task automatic test_scoreboard();
    read_reg_1 = 5'd9; read_reg_2 = 5'd10;
    busy_set_reg = 5'd9; signal_busy_set = 1'b1;
    tick();
    idle_inputs();
    settle();
    total++; if ({busy_1, busy_2, busy_any} !== 3'b101) begin bad++; $display("FAIL sb_set: got %b want 101", {busy_1, busy_2, busy_any}); end
    // B retires the old producer while a new one is issued to the same reg.
    write_reg_b = 5'd9; write_data_b = 32'h99; signal_reg_write_b = 1'b1;
    busy_set_reg = 5'd9; signal_busy_set = 1'b1;
    settle();
    total++; if ({busy_1, busy_any} !== 2'b01) begin bad++; $display("FAIL sb_bypass_busy: got %b want 01", {busy_1, busy_any}); end
    tick();
    idle_inputs();
    settle();
    total++; if ({busy_1, busy_any} !== 2'b11) begin bad++; $display("FAIL sb_set_wins: got %b want 11", {busy_1, busy_any}); end
    total++; if (read_data_1 !== 32'h99) begin bad++; $display("FAIL sb_data: got %h want %h", read_data_1, 32'h99); end
    write_reg_a = 5'd9; write_data_a = 32'h123; signal_reg_write_a = 1'b1;
    settle();
    total++; if ({busy_1, busy_any} !== 2'b01) begin bad++; $display("FAIL sb_clear_bypass: got %b want 01", {busy_1, busy_any}); end
    tick();
    idle_inputs();
    settle();
    total++; if ({busy_1, busy_any} !== 2'b00) begin bad++; $display("FAIL sb_cleared: got %b want 00", {busy_1, busy_any}); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i < 32; i++) begin
      write_reg_a = 5'(i); write_data_a = 32'h1000 + 32'(i); signal_reg_write_a = 1'b1;
      tick();
    end
    idle_inputs();
    busy_set_reg = 5'd2; signal_busy_set = 1'b1;
    tick();
    busy_set_reg = 5'd6;
    tick();
    idle_inputs();
    read_reg_1 = 5'd2; read_reg_2 = 5'd31;
    settle();
    total++; if (read_data_2 !== 32'h101F) begin bad++; $display("FAIL mid_fill31: got %h want %h", read_data_2, 32'h101F); end
    total++; if ({busy_1, busy_any} !== 2'b11) begin bad++; $display("FAIL mid_busy_pre: got %b want 11", {busy_1, busy_any}); end
    rst = 1'b1;
    write_reg_a = 5'd2; write_data_a = 32'h55; signal_reg_write_a = 1'b1;
    settle();
    // No bypass through reset: the pre-reset array value is shown.
    total++; if (read_data_1 !== 32'h1002) begin bad++; $display("FAIL mid_no_bypass_rst: got %h want %h", read_data_1, 32'h1002); end
    tick();
    rst = 1'b0;
    idle_inputs();
    settle();
    total++; if (busy_any !== 1'b0) begin bad++; $display("FAIL mid_busy_any: got %b want 0", busy_any); end
    for (int i = 0; i < 32; i++) begin
      read_reg_1 = 5'(i); read_reg_2 = 5'(31 - i);
      #1;
      total++; if (read_data_1 !== 32'h0 || busy_1 !== 1'b0) begin bad++; $display("FAIL mid_clear_r%0d: got %h/%b want 0/0", i, read_data_1, busy_1); end
    end
  endtask

  task automatic test_param_sweep();
    p_read_reg_1 = 3'd0; p_read_reg_2 = 3'd7;
    p_write_reg_a = 3'd0; p_write_data_a = 16'hABCD; p_we_a = 1'b1;
    p_write_reg_b = 3'd7; p_write_data_b = 16'h7777; p_we_b = 1'b1;
    p_busy_set_reg = 3'd6; p_bset = 1'b1;
    settle();
    total++; if (p_read_data_1 !== 16'h0) begin bad++; $display("FAIL p_no_bypass0: got %h want %h", p_read_data_1, 16'h0); end
    total++; if (p_read_data_2 !== 16'h0) begin bad++; $display("FAIL p_no_bypass7: got %h want %h", p_read_data_2, 16'h0); end
    tick();
    idle_inputs();
    settle();
    total++; if (p_read_data_1 !== 16'hABCD) begin bad++; $display("FAIL p_reg0: got %h want %h", p_read_data_1, 16'hABCD); end
    total++; if (p_read_data_2 !== 16'h7777) begin bad++; $display("FAIL p_reg7: got %h want %h", p_read_data_2, 16'h7777); end
    p_read_reg_1 = 3'd6;
    settle();
    total++; if ({p_read_data_1, p_busy_1, p_busy_any} !== {16'h0, 2'b11}) begin bad++; $display("FAIL p_reg6: got %h/%b/%b want 0000/1/1", p_read_data_1, p_busy_1, p_busy_any); end
    // Register 0 is an ordinary register here, so it can be marked busy.
    p_busy_set_reg = 3'd0; p_bset = 1'b1;
    p_read_reg_1 = 3'd0;
    tick();
    idle_inputs();
    p_write_reg_a = 3'd0; p_write_data_a = 16'h1234; p_we_a = 1'b1;
    settle();
    total++; if ({p_read_data_1, p_busy_1} !== {16'hABCD, 1'b1}) begin bad++; $display("FAIL p_busy0_nobyp: got %h/%b want abcd/1", p_read_data_1, p_busy_1); end
    tick();
    idle_inputs();
    settle();
    total++; if ({p_read_data_1, p_busy_1} !== {16'h1234, 1'b0}) begin bad++; $display("FAIL p_busy0_clear: got %h/%b want 1234/0", p_read_data_1, p_busy_1); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    rst = 1'b1; p_rst = 1'b1;
    read_reg_1 = '0; read_reg_2 = '0; p_read_reg_1 = '0; p_read_reg_2 = '0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_collision();
    test_zero_reg();
    test_scoreboard();
    test_reset_mid();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
